// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use bubbles, taken-branch flushes and multi-cycle data-memory
// accesses. It also runs a watchdog on memory waits (sticky timeout) and a
// saturating count of PC-stall cycles.
module hazard_ctrl #(
   parameter int WAIT_W   = 8,
   parameter int MAX_WAIT = 200
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  IF_ID_RSaddr_i,
   input  logic [4:0]  IF_ID_RTaddr_i,
   input  logic        ID_EX_MemRead_i,
   input  logic [4:0]  ID_EX_RTaddr_i,
   input  logic        Branch_taken_i,
   input  logic        MEM_req_i,
   input  logic        MEM_ack_i,
   output logic        PCWrite_o,
   output logic        IF_ID_Write_o,
   output logic        IF_ID_Flush_o,
   output logic        ID_EX_Bubble_o,
   output logic        Pipe_Stall_o,
   output logic        Timeout_o,
   output logic [15:0] Stall_cnt_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } state_t;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

   state_t              state_q, state_d, cur_state_s;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                timeout_q, timeout_d;
   logic [15:0]         stall_cnt_q, stall_cnt_d;
   logic                load_use_s;
   logic                run_rules_s;

   // While reset is asserted the outputs follow RUN rules, whatever the stored state.
   always_comb begin
      if (rst_i) begin
         cur_state_s = RUN;
      end else begin
         cur_state_s = state_q;
      end
   end

   // Load-use: a load in EX whose (non-zero) destination is read by the instruction in ID.
   always_comb begin
      load_use_s = ID_EX_MemRead_i && (ID_EX_RTaddr_i != 5'd0) &&
                   ((ID_EX_RTaddr_i == IF_ID_RSaddr_i) ||
                    (ID_EX_RTaddr_i == IF_ID_RTaddr_i));
   end

   // Next-state logic and Mealy hazard outputs; memory freeze > load-use > branch flush.
   always_comb begin
      PCWrite_o      = 1'b1;
      IF_ID_Write_o  = 1'b1;
      IF_ID_Flush_o  = 1'b0;
      ID_EX_Bubble_o = 1'b0;
      Pipe_Stall_o   = 1'b0;
      run_rules_s    = 1'b0;
      state_d        = cur_state_s;
      wait_cnt_d     = wait_cnt_q;

      case (cur_state_s)
         RUN: begin
            if (MEM_req_i && !MEM_ack_i) begin
               PCWrite_o     = 1'b0;
               IF_ID_Write_o = 1'b0;
               Pipe_Stall_o  = 1'b1;
               state_d       = MEM_WAIT;
               wait_cnt_d    = '0;
            end else begin
               // A same-cycle ack is a hit; an ack with no request is ignored.
               run_rules_s = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (!MEM_ack_i) begin
               PCWrite_o     = 1'b0;
               IF_ID_Write_o = 1'b0;
               Pipe_Stall_o  = 1'b1;
               if (wait_cnt_q == WAIT_LAST) begin
                  state_d = ERROR;
               end else begin
                  wait_cnt_d = wait_cnt_q + 1'b1;
               end
            end else begin
               // Freeze is released on the ack cycle, so ID hazards resolve right away.
               run_rules_s = 1'b1;
               state_d     = RUN;
               wait_cnt_d  = '0;
            end
         end
         ERROR: begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            Pipe_Stall_o  = 1'b1;
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase

      if (run_rules_s) begin
         if (load_use_s) begin
            // A coincident taken branch is dropped; it is re-evaluated next cycle.
            PCWrite_o      = 1'b0;
            IF_ID_Write_o  = 1'b0;
            ID_EX_Bubble_o = 1'b1;
         end else if (Branch_taken_i) begin
            IF_ID_Flush_o = 1'b1;
         end else begin
            IF_ID_Flush_o = 1'b0;
         end
      end else begin
         ID_EX_Bubble_o = 1'b0;
      end
   end

   // Sticky timeout flag and saturating stall-cycle counter.
   always_comb begin
      timeout_d = timeout_q || (state_d == ERROR);
      if (!PCWrite_o && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign Timeout_o   = timeout_q;
   assign Stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench for hazard_ctrl with a behavioural model.
// The driver pushes the expected outputs for each cycle into a queue, and a
// monitor on the falling edge pops and compares them.
module tb_hazard_ctrl;

   localparam int MAX_WAIT = 4;

   logic        clk;
   logic        rst;
   logic [4:0]  rs, rt, ldrt;
   logic        memread, br, req, ack;
   logic        pc_w, ifid_w, ifid_f, bub, pstall, tmo;
   logic [15:0] scnt;

   hazard_ctrl #(.WAIT_W(8), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk), .rst_i(rst),
      .IF_ID_RSaddr_i(rs), .IF_ID_RTaddr_i(rt),
      .ID_EX_MemRead_i(memread), .ID_EX_RTaddr_i(ldrt),
      .Branch_taken_i(br), .MEM_req_i(req), .MEM_ack_i(ack),
      .PCWrite_o(pc_w), .IF_ID_Write_o(ifid_w), .IF_ID_Flush_o(ifid_f),
      .ID_EX_Bubble_o(bub), .Pipe_Stall_o(pstall),
      .Timeout_o(tmo), .Stall_cnt_o(scnt)
   );

   // Clock starts high so the first falling edge precedes the first rising edge.
   initial begin
      clk = 1'b1;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          pc, ifid, flush, bub, stall, to;
      bit   [15:0] cnt;
      bit          known;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_mis = 0;

   // Reference model: miss streak = consecutive frozen cycles since the last release.
   int m_streak = 0;
   bit m_err    = 1'b0;
   int m_cnt    = 0;
   bit m_known  = 1'b0;
   bit last_bub = 1'b0;

   task automatic apply(input bit r, input bit [4:0] a_rs, input bit [4:0] a_rt,
                        input bit mr, input bit [4:0] a_ld, input bit a_br,
                        input bit a_req, input bit a_ack);
      exp_t e;
      bit   frozen, lu;
      rst = r; rs = a_rs; rt = a_rt; memread = mr; ldrt = a_ld;
      br = a_br; req = a_req; ack = a_ack;
      e.pc = 1; e.ifid = 1; e.flush = 0; e.bub = 0; e.stall = 0;
      e.to = m_err; e.cnt = 16'(m_cnt); e.known = m_known;
      frozen = 1'b0;
      if (m_err && !r) begin
         e.pc = 0; e.ifid = 0; e.stall = 1;
      end else begin
         frozen = !a_ack && (a_req || (!r && m_streak > 0));
         lu = mr && (a_ld != 5'd0) && (a_ld == a_rs || a_ld == a_rt);
         if (frozen) begin
            e.pc = 0; e.ifid = 0; e.stall = 1;
         end else if (lu) begin
            e.pc = 0; e.ifid = 0; e.bub = 1;
         end else if (a_br) begin
            e.flush = 1;
         end
      end
      q.push_back(e);
      @(posedge clk);
      if (r) begin
         m_streak = 0; m_err = 0; m_cnt = 0; m_known = 1;
      end else begin
         if (!e.pc && m_cnt < 65535) m_cnt++;
         if (!m_err) begin
            if (frozen) begin
               m_streak++;
               if (m_streak == MAX_WAIT + 1) m_err = 1'b1;
            end else begin
               m_streak = 0;
            end
         end
      end
      last_bub = e.bub;
      #1;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
      if (act !== expv) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (vector %0d, t=%0t)", nm, act, expv, n_vec, $time);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest pending expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         n_vec++;
         chk("PCWrite",    16'(pc_w),   16'(e.pc));
         chk("IF_ID_Write", 16'(ifid_w), 16'(e.ifid));
         chk("IF_ID_Flush", 16'(ifid_f), 16'(e.flush));
         chk("ID_EX_Bubble", 16'(bub),  16'(e.bub));
         chk("Pipe_Stall", 16'(pstall), 16'(e.stall));
         if (e.known) begin
            chk("Timeout",   16'(tmo), 16'(e.to));
            chk("Stall_cnt", scnt,     e.cnt);
         end
      end
   end

   // Stimulus: directed scenarios, random traffic, then counter saturation.
   initial begin
      bit slow;
      bit r_s, mr_s, br_s, rq_s, ak_s;
      slow = 1'b0;
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      // load-use rt=5/rs=5, then EX holds the bubble
      apply(0, 5, 1, 1, 5, 0, 0, 0);
      apply(0, 5, 1, 0, 5, 0, 0, 0);
      // load to r0 never stalls
      apply(0, 0, 0, 1, 0, 0, 0, 0);
      // taken branch, then branch coinciding with load-use
      apply(0, 1, 2, 0, 0, 1, 0, 0);
      apply(0, 5, 1, 1, 5, 1, 0, 0);
      apply(0, 5, 1, 0, 5, 1, 0, 0);
      // miss acked on the third cycle after the request
      apply(0, 1, 2, 0, 0, 0, 1, 0);
      apply(0, 1, 2, 0, 0, 0, 1, 0);
      apply(0, 1, 2, 0, 0, 0, 1, 0);
      apply(0, 1, 2, 0, 0, 0, 1, 1);
      // hit, and ack without request
      apply(0, 1, 2, 0, 0, 0, 1, 1);
      apply(0, 1, 2, 0, 0, 0, 0, 1);
      // miss overlapping a load-use: bubble only on the ack cycle
      apply(0, 5, 1, 1, 5, 0, 1, 0);
      apply(0, 5, 1, 1, 5, 0, 1, 0);
      apply(0, 5, 1, 1, 5, 0, 1, 1);
      apply(0, 5, 1, 0, 5, 0, 0, 0);
      // never-acked request: timeout, sticky, then reset
      for (int i = 0; i < 9; i++) apply(0, 1, 2, 0, 0, 0, 1, 0);
      apply(0, 1, 2, 0, 0, 1, 0, 1);
      apply(1, 1, 2, 0, 0, 0, 1, 0);
      apply(0, 1, 2, 0, 0, 0, 0, 0);
      apply(0, 1, 2, 0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) slow = ~slow;
         r_s  = ($urandom_range(0, 199) == 0) || (m_err && $urandom_range(0, 7) == 0);
         mr_s = last_bub ? 1'b0 : 1'($urandom_range(0, 1));
         br_s = ($urandom_range(0, 3) == 0);
         rq_s = (m_streak > 0 && !m_err) ? 1'b1 : ($urandom_range(0, 3) == 0);
         ak_s = ($urandom_range(0, slow ? 9 : 2) == 0);
         apply(r_s, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), mr_s,
               5'($urandom_range(0, 3)), br_s, rq_s, ak_s);
      end

      // long ERROR drives the stall counter into saturation
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65560; i++) apply(0, 1, 2, 0, 0, 0, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0);
      apply(0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         n_mis++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
